// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared constants for the instruction fetch stage: instruction width, the
//   NOP bubble encoding, the opcode field position and the HALT opcode, plus a
//   helper that extracts the opcode field.
//   Optional feature macro used by the fetch stage: FETCH_HALT_EN.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int INSTR_W = 20;
    localparam int QDEPTH  = 2;

    // Opcode occupies the top five bits of every instruction.
    localparam int OPC_HI = 19;
    localparam int OPC_LO = 15;
    localparam int OPC_W  = OPC_HI - OPC_LO + 1;

    localparam logic [INSTR_W-1:0] NOP_INSTR   = 20'h00000;
    localparam logic [OPC_W-1:0]   HALT_OPCODE = 5'h1F;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Bundles the instruction-ROM read port and the decode-side signals of the
//   fetch stage.
//   master : fetch stage (drives ROM request and decode outputs)
//   slave  : environment (ROM data, stall, branch redirect)
//   Signals:
//     imem_rd_en/imem_addr  ROM read request and address
//     imem_rdata            ROM data, valid the cycle after the request
//     stall                 hold current instruction, no pop
//     branch_taken/target   redirect pulse and new PC
//     instr_out/valid/pc_out instruction to decode, NOP when not valid
//     halted                fetch stopped on HALT (FETCH_HALT_EN builds)
// -----------------------------------------------------------------------------
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int PC_W = 10
);
    logic               imem_rd_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic [PC_W-1:0]    pc_out;
    logic               halted;

    modport master (
        output imem_rd_en, imem_addr, instr_out, instr_valid, pc_out, halted,
        input  imem_rdata, stall, branch_taken, branch_target
    );

    modport slave (
        input  imem_rd_en, imem_addr, instr_out, instr_valid, pc_out, halted,
        output imem_rdata, stall, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_stage_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Two-entry FIFO of {instruction, pc} pairs used as the fetch prefetch queue.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     i_clear           flush all entries (branch redirect)
//     i_push            write {i_instr, i_pc} at the tail
//     i_pop             drop the head entry (ignored when empty)
//     o_valid, o_count  head present, number of entries
//     o_instr, o_pc     head entry contents (raw, meaningful when o_valid)
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int PC_W = 10
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic               o_valid,
    output logic [1:0]         o_count,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc
);

    logic [INSTR_W-1:0] r_instr [QDEPTH];
    logic [PC_W-1:0]    r_pc    [QDEPTH];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_count;
    logic               w_pop;

    assign w_pop = i_pop & (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            // The issue gating upstream guarantees a free slot for every push.
            assert (!(i_push && r_count == 2'(QDEPTH)));
            if (i_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed through r_count.
    always_ff @(posedge clk) begin
        if (!rst && !i_clear && i_push) begin
            r_instr[r_wr_ptr] <= i_instr;
            r_pc[r_wr_ptr]    <= i_pc;
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;
    assign o_instr = r_instr[r_rd_ptr];
    assign o_pc    = r_pc[r_rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage feeding decode. Holds the PC, issues reads to a
//   one-cycle synchronous instruction ROM, buffers returned instructions in a
//   two-entry prefetch queue and presents the head to decode, holding it under
//   stall. A branch redirect flushes the queue and squashes the in-flight read.
//   Optional macro FETCH_HALT_EN: a pushed HALT opcode stops further fetch
//   until reset or a redirect; without it 'halted' is tied low.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     bus        fetch_stage_if.master (ROM port + decode-side signals)
//   Parameters:
//     PC_W       PC / ROM address width, PC wraps modulo 2**PC_W
//     RESET_PC   PC loaded on reset
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
)(
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_infl_pc;     // address of the read in flight
    logic               r_inflight;
    logic               r_epoch;       // toggles on every redirect
    logic               r_infl_epoch;  // epoch the in-flight read was issued in

    logic               w_halted;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_q_valid;
    logic [1:0]         w_q_count;
    logic [1:0]         w_occ;
    logic [INSTR_W-1:0] w_q_instr;
    logic [PC_W-1:0]    w_q_pc;

    // Queue entries plus the read still in flight must never exceed the
    // queue depth, so a returning response always has a slot.
    assign w_occ   = w_q_count + {1'b0, r_inflight};
    assign w_issue = !rst && !bus.branch_taken && !w_halted && (w_occ < 2'(QDEPTH));

    // A response from an older epoch belongs to a squashed fetch path.
    assign w_push  = r_inflight && (r_infl_epoch == r_epoch)
                     && !bus.branch_taken && !w_halted;
    assign w_pop   = w_q_valid && !bus.stall && !bus.branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_infl_pc    <= '0;
            r_inflight   <= 1'b0;
            r_epoch      <= 1'b0;
            r_infl_epoch <= 1'b0;
        end else if (bus.branch_taken) begin
            r_pc       <= bus.branch_target;
            r_inflight <= 1'b0;
            r_epoch    <= ~r_epoch;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_infl_pc    <= r_pc;
                r_infl_epoch <= r_epoch;
                r_pc         <= r_pc + 1'b1;
            end
        end
    end

`ifdef FETCH_HALT_EN
    logic r_halted;
    logic w_halt_hit;

    assign w_halt_hit = w_push && (opcode_of(bus.imem_rdata) == HALT_OPCODE);

    // The HALT itself is queued; anything issued alongside it is dropped
    // because w_push is gated by the halted flag from the next cycle on.
    always_ff @(posedge clk) begin
        if (rst || bus.branch_taken) r_halted <= 1'b0;
        else if (w_halt_hit)         r_halted <= 1'b1;
    end

    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

    fetch_queue #(.PC_W(PC_W)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.branch_taken),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_instr (bus.imem_rdata),
        .i_pc    (r_infl_pc),
        .o_valid (w_q_valid),
        .o_count (w_q_count),
        .o_instr (w_q_instr),
        .o_pc    (w_q_pc)
    );

    assign bus.imem_rd_en  = w_issue;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = w_q_valid;
    assign bus.instr_out   = w_q_valid ? w_q_instr : NOP_INSTR;
    assign bus.pc_out      = w_q_valid ? w_q_pc : '0;
    assign bus.halted      = w_halted;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_stage_pkg::*;

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;
    int   halt_addr = -1;

    always #5 clk = ~clk;

    fetch_stage_if #(.PC_W(10)) bus ();

    fetch_stage #(.PC_W(10), .RESET_PC(10'h000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM image: address + 0x100, with an optional HALT word.
    function automatic logic [19:0] rom(input logic [9:0] a);
        if (int'(a) == halt_addr) return {HALT_OPCODE, 5'd0, a};
        return 20'h100 + {10'd0, a};
    endfunction

    always @(posedge clk) if (bus.imem_rd_en) bus.imem_rdata <= rom(bus.imem_addr);

    // Reference model: a queue of fetched words, the fetch PC and one
    // optional outstanding read.
    logic [19:0] m_qi [$];
    logic [9:0]  m_qp [$];
    logic [9:0]  m_pc = 10'h000;
    logic        m_infl = 1'b0;
    logic [9:0]  m_infl_pc = 10'h000;
    logic        m_halted = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic        e_v, e_rd;
        logic [19:0] e_i, d;
        logic [9:0]  e_p;
        #1;
        e_v  = (m_qi.size() > 0);
        e_i  = e_v ? m_qi[0] : NOP_INSTR;
        e_p  = e_v ? m_qp[0] : 10'h000;
        e_rd = !rst && !bus.branch_taken && !m_halted && ((m_qi.size() + int'(m_infl)) < 2);
        chk("instr_valid", 32'(bus.instr_valid), 32'(e_v));
        chk("instr_out",   32'(bus.instr_out),   32'(e_i));
        chk("pc_out",      32'(bus.pc_out),      32'(e_p));
        chk("imem_rd_en",  32'(bus.imem_rd_en),  32'(e_rd));
        chk("imem_addr",   32'(bus.imem_addr),   32'(m_pc));
        chk("halted",      32'(bus.halted),      32'(m_halted));
        @(posedge clk);
        if (rst) begin
            m_qi.delete(); m_qp.delete();
            m_pc = 10'h000; m_infl = 1'b0; m_halted = 1'b0;
        end else if (bus.branch_taken) begin
            m_qi.delete(); m_qp.delete();
            m_pc = bus.branch_target; m_infl = 1'b0; m_halted = 1'b0;
        end else begin
            if (e_v && !bus.stall) begin
                void'(m_qi.pop_front()); void'(m_qp.pop_front());
            end
            if (m_infl && !m_halted) begin
                d = rom(m_infl_pc);
                m_qi.push_back(d); m_qp.push_back(m_infl_pc);
                if (HALT_EN && d[19:15] == HALT_OPCODE) m_halted = 1'b1;
            end
            m_infl = e_rd;
            if (e_rd) begin
                m_infl_pc = m_pc;
                m_pc = m_pc + 10'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic redirect(input logic [9:0] t, input logic st);
        bus.branch_taken = 1'b1; bus.branch_target = t; bus.stall = st;
        cycle();
        bus.branch_taken = 1'b0; bus.stall = 1'b0;
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 10'h000;
        @(posedge clk);
        @(negedge clk);

        // Reset state, then free run: first valid two edges after release.
        run(2);
        rst = 1'b0;
        run(12);

        // Stall while pc 3 is at the head, queue fills and fetch pauses.
        redirect(10'h000, 1'b0);
        for (int k = 0; k < 20 && !(m_qi.size() > 0 && m_qp[0] == 10'h003); k++) cycle();
        chk("head_at_3", 32'(bus.pc_out), 32'h3);
        bus.stall = 1'b1;
        run(4);
        bus.stall = 1'b0;
        run(6);

        // Redirect with a full queue, and with a read in flight.
        bus.stall = 1'b1;
        run(4);
        redirect(10'h040, 1'b1);
        run(6);
        redirect(10'h050, 1'b0);
        run(5);

        // Branch and stall together: redirect wins.
        redirect(10'h080, 1'b1);
        bus.stall = 1'b1;
        run(3);
        bus.stall = 1'b0;
        run(3);

        // PC wrap.
        redirect(10'h3FE, 1'b0);
        run(10);

        // HALT word at address 5.
        halt_addr = 5;
        redirect(10'h000, 1'b0);
        run(15);
        redirect(10'h010, 1'b0);
        run(6);

        // Reset with a read in flight.
        run(1);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(5);

        // Random mix of stalls, redirects and resets.
        for (int k = 0; k < 600; k++) begin
            bus.stall = ($urandom_range(0, 99) < 30);
            bus.branch_taken = ($urandom_range(0, 99) < 6);
            bus.branch_target = 10'($urandom_range(0, 1023));
            rst = ($urandom_range(0, 99) < 2);
            cycle();
        end
        rst = 1'b0;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        run(4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
